// File: rtl/truth_table_checker.sv
// Response checker for truth-table benches: waits out a settle window after each
// input-vector change, compares the DUT output to EXPECTED and tracks coverage.
module truth_table_checker #(
  parameter int N_IN = 2,
  parameter logic [(1 << N_IN)-1:0] EXPECTED = 4'b1100,
  parameter int SETTLE = 3,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_IN-1:0]        vec_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic                   err_pulse,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [(1 << N_IN)-1:0] covered,
  output logic [N_IN-1:0]        first_fail_vec,
  output logic                   first_fail_valid,
  output logic [1:0]             state_dbg
);

  localparam int NV = 1 << N_IN;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   prev_vec_q, prev_vec_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic [NV-1:0]     covered_q, covered_d;
  logic [N_IN-1:0]   first_fail_vec_q, first_fail_vec_d;
  logic              first_fail_valid_q, first_fail_valid_d;

  logic              change;
  logic              mism;
  logic [NV-1:0]     covered_new;
  logic [IDLE_W-1:0] idle_inc;

  assign change      = (vec_in != prev_vec_q);
  assign mism        = (dut_out != EXPECTED[vec_in]);
  assign covered_new = covered_q | (NV'(1) << vec_in);
  assign idle_inc    = idle_q + IDLE_W'(1);

  always_comb begin
    state_d            = state_q;
    prev_vec_d         = vec_in;
    cnt_d              = cnt_q;
    idle_d             = idle_q;
    busy_d             = busy_q;
    done_d             = done_q;
    pass_d             = pass_q;
    timeout_d          = timeout_q;
    err_pulse_d        = 1'b0;
    mismatch_cnt_d     = mismatch_cnt_q;
    covered_d          = covered_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;

    // start wins in every state and behaves like a vector change edge
    if (start) begin
      state_d            = S_SETTLE;
      cnt_d              = 8'(SETTLE);
      idle_d             = '0;
      busy_d             = 1'b1;
      done_d             = 1'b0;
      pass_d             = 1'b0;
      timeout_d          = 1'b0;
      mismatch_cnt_d     = '0;
      covered_d          = '0;
      first_fail_vec_d   = '0;
      first_fail_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (change) begin
            cnt_d = 8'(SETTLE);
          end else if (cnt_q == 8'd0) begin
            covered_d = covered_new;
            if (mism) begin
              err_pulse_d = 1'b1;
              if (mismatch_cnt_q != {CNT_W{1'b1}}) begin
                mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
              end
              if (!first_fail_valid_q) begin
                first_fail_vec_d   = vec_in;
                first_fail_valid_d = 1'b1;
              end
            end
            if (&covered_new) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (mismatch_cnt_d == '0);
            end else begin
              state_d = S_WAIT;
              idle_d  = '0;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_WAIT: begin
          if (change) begin
            state_d = S_SETTLE;
            cnt_d   = 8'(SETTLE);
          end else if (idle_inc == IDLE_W'(TIMEOUT)) begin
            state_d   = S_DONE;
            idle_d    = idle_inc;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      prev_vec_q         <= '0;
      cnt_q              <= '0;
      idle_q             <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      timeout_q          <= 1'b0;
      err_pulse_q        <= 1'b0;
      mismatch_cnt_q     <= '0;
      covered_q          <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      prev_vec_q         <= prev_vec_d;
      cnt_q              <= cnt_d;
      idle_q             <= idle_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
      timeout_q          <= timeout_d;
      err_pulse_q        <= err_pulse_d;
      mismatch_cnt_q     <= mismatch_cnt_d;
      covered_q          <= covered_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign timeout          = timeout_q;
  assign err_pulse        = err_pulse_q;
  assign mismatch_cnt     = mismatch_cnt_q;
  assign covered          = covered_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign first_fail_valid = first_fail_valid_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: default instance plus a CNT_W=2 instance sharing
// the same stimulus; err_pulse and session results are scoreboarded.
module tb_truth_table_checker;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst, start, dut_out;
  logic [1:0] vec_in;

  logic       busy, done, pass, timeout, err_pulse, ffv;
  logic [7:0] mcnt;
  logic [3:0] covered;
  logic [1:0] ffvec, state_dbg;

  logic       busy2, done2, pass2, timeout2, err_pulse2, ffv2;
  logic [1:0] mcnt2;
  logic [3:0] covered2;
  logic [1:0] ffvec2, state_dbg2;

  truth_table_checker dut (
    .clk(clk), .rst(rst), .start(start), .vec_in(vec_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_pulse(err_pulse),
    .mismatch_cnt(mcnt), .covered(covered), .first_fail_vec(ffvec),
    .first_fail_valid(ffv), .state_dbg(state_dbg)
  );

  truth_table_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .vec_in(vec_in), .dut_out(dut_out),
    .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2), .err_pulse(err_pulse2),
    .mismatch_cnt(mcnt2), .covered(covered2), .first_fail_vec(ffvec2),
    .first_fail_valid(ffv2), .state_dbg(state_dbg2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [1:0]  exp_q[$];
  logic [16:0] res_q[$];
  logic        done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Intended gate: out = A + A*B with A = vec[1], B = vec[0]
  function automatic logic ref_out(input logic [1:0] v);
    return v[1] | (v[1] & v[0]);
  endfunction

  function automatic logic [16:0] mk_res(input logic [3:0] cov, input logic [7:0] mc,
                                         input logic p, input logic to,
                                         input logic fv, input logic [1:0] fvec);
    return {cov, mc, p, to, fv, fvec};
  endfunction

  // Drive vector v for 'hold' edges; the vector is sampled only if held SETTLE+2 edges.
  task automatic apply_vec(input logic [1:0] v, input int hold, input logic force1, input logic st);
    @(negedge clk);
    vec_in  = v;
    dut_out = force1 ? 1'b1 : ref_out(v);
    start   = st;
    if (hold >= SETTLE + 2 && dut_out != ref_out(v)) exp_q.push_back(v);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (hold - 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    logic [16:0] r;
    if (err_pulse) begin
      if (exp_q.size() == 0) check("err_unexpected", err_pulse, 0);
      else check("err_vec", vec_in, exp_q.pop_front());
    end
    if (done && !done_prev) begin
      if (res_q.size() == 0) begin
        check("done_unexpected", done, 0);
      end else begin
        r = res_q.pop_front();
        check("res_covered", covered, r[16:13]);
        check("res_mcnt", mcnt, r[12:5]);
        check("res_pass", pass, r[4]);
        check("res_timeout", timeout, r[3]);
        check("res_ffv", ffv, r[2]);
        check("res_ffvec", ffvec, r[1:0]);
      end
    end
    done_prev = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; vec_in = 2'b00; dut_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_covered", covered, 0);
    check("rst_mcnt", mcnt, 0);
    @(negedge clk) rst = 1'b0;

    // T1: correct DUT, all four vectors
    res_q.push_back(mk_res(4'hf, 8'd0, 1'b1, 1'b0, 1'b0, 2'b00));
    apply_vec(2'b00, 10, 1'b0, 1'b1);
    check("t1_busy", busy, 1);
    apply_vec(2'b01, 10, 1'b0, 1'b0);
    apply_vec(2'b10, 10, 1'b0, 1'b0);
    check("t1_cov3", covered, 4'b0111);
    apply_vec(2'b11, 4, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_done_early", done, 0);
    @(posedge clk);
    #1;
    check("t1_done_lat", done, 1);
    check("t1_busy_off", busy, 0);
    check("t1_pass", pass, 1);
    repeat (5) @(posedge clk);

    // T2: stuck-at-1 DUT mismatches on 00 and 01
    res_q.push_back(mk_res(4'hf, 8'd2, 1'b0, 1'b0, 1'b1, 2'b00));
    apply_vec(2'b00, 10, 1'b1, 1'b1);
    apply_vec(2'b01, 10, 1'b1, 1'b0);
    apply_vec(2'b10, 10, 1'b1, 1'b0);
    apply_vec(2'b11, 10, 1'b1, 1'b0);
    check("t2_mcnt_sat_inst", mcnt2, 2);

    // T3: 01 too short, session times out
    res_q.push_back(mk_res(4'b1101, 8'd0, 1'b0, 1'b1, 1'b0, 2'b00));
    apply_vec(2'b00, 10, 1'b0, 1'b1);
    apply_vec(2'b01, 2, 1'b0, 1'b0);
    apply_vec(2'b10, 10, 1'b0, 1'b0);
    apply_vec(2'b11, 10, 1'b0, 1'b0);
    check("t3_busy", busy, 1);
    check("t3_cov", covered, 4'b1101);
    repeat (58) @(posedge clk);
    #1 check("t3_done_early", done, 0);
    @(posedge clk);
    #1;
    check("t3_done", done, 1);
    check("t3_timeout", timeout, 1);

    // T4: vector toggles every 2 edges, never sampled
    apply_vec(2'b00, 2, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) apply_vec((i % 2 == 0) ? 2'b01 : 2'b00, 2, 1'b0, 1'b0);
    check("t4_cov", covered, 0);
    check("t4_state", state_dbg, 1);
    check("t4_busy", busy, 1);

    // T5: stuck-at-1 DUT, 00/01 pair six times
    for (int i = 0; i < 6; i++) begin
      apply_vec(2'b00, 10, 1'b1, (i == 0));
      apply_vec(2'b01, 10, 1'b1, 1'b0);
    end
    check("t5_mcnt", mcnt, 12);
    check("t5_mcnt_sat", mcnt2, 3);
    check("t5_ffv", ffv, 1);
    check("t5_ffvec", ffvec, 2'b00);
    check("t5_done", done, 0);

    // T6: async reset mid-SETTLE, then start mid-WAIT
    apply_vec(2'b00, 10, 1'b1, 1'b1);
    apply_vec(2'b01, 10, 1'b1, 1'b0);
    apply_vec(2'b10, 2, 1'b1, 1'b0);
    check("t6_cov_pre", covered, 4'b0011);
    check("t6_state_pre", state_dbg, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cov", covered, 0);
    check("t6_rst_mcnt", mcnt, 0);
    check("t6_rst_ffv", ffv, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_state", state_dbg, 0);
    #1 rst = 1'b0;
    res_q.push_back(mk_res(4'hf, 8'd0, 1'b1, 1'b0, 1'b0, 2'b00));
    apply_vec(2'b00, 10, 1'b0, 1'b1);
    check("t6_wait", state_dbg, 2);
    check("t6_cov1", covered, 4'b0001);
    apply_vec(2'b01, 1, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_restart_cov", covered, 0);
    check("t6_restart_state", state_dbg, 1);
    apply_vec(2'b01, 9, 1'b0, 1'b0);
    apply_vec(2'b10, 10, 1'b0, 1'b0);
    apply_vec(2'b11, 10, 1'b0, 1'b0);
    apply_vec(2'b00, 10, 1'b0, 1'b0);
    check("t6_done", done, 1);
    check("t6_pass", pass, 1);

    repeat (3) @(posedge clk);
    check("err_q_empty", exp_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Synthesizable response checker for the gate-level function benches: the receiving end of the truth-table stimulus sequence. It watches the input vector applied to a combinational DUT and the DUT output. After each vector change and a settle window, it compares the output against a parameterized expected truth table. It tracks which input combinations have been covered, counts mismatches, captures the first failing vector, and reports pass/fail once every combination has been checked or the stimulus stalls.

## Interface
- `N_IN`, 2: number of DUT inputs, 1..4; `vec_in[N_IN-1]` is the first-listed input (A).
- `EXPECTED`, 4'b1100: expected output, bit i = response to `vec_in == i`; width 2^N_IN (default = A + A·B).
- `SETTLE`, 3: clock edges to wait after a vector change before sampling, 0..255.
- `TIMEOUT`, 64: idle edges without a vector change before aborting, ≥1.
- `CNT_W`, 8: mismatch counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; clears all results and begins a check session.
- `vec_in`  in  N_IN  vector currently driven into the DUT.
- `dut_out`  in  1  DUT output.
- `busy`  out  1  session in progress.
- `done`  out  1  session finished; held until `start` or `rst`.
- `pass`  out  1  valid with `done`: full coverage, zero mismatches, no timeout.
- `timeout`  out  1  session ended by stall.
- `err_pulse`  out  1  one-cycle pulse on each mismatching sample.
- `mismatch_cnt`  out  CNT_W  mismatch count, saturating at all-ones.
- `covered`  out  2^N_IN  bit i set once vector i has been sampled.
- `first_fail_vec`  out  N_IN  vector of the first mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` holds a captured value.

## Operation
- The block uses a four-state machine: IDLE, SETTLE, WAIT, DONE. All outputs are registered.
- `prev_vec` captures `vec_in` every edge. A change is `vec_in != prev_vec` at an edge.
- IDLE: outputs hold. `start` → SETTLE. The start edge clears `covered`, `mismatch_cnt`, `first_fail_*`, `timeout`, `done` and `pass`, and loads `cnt` ← SETTLE.
- SETTLE:
  - A change reloads `cnt` ← SETTLE and stays in SETTLE.
  - Otherwise, if `cnt`==0, the block samples.
  - Otherwise `cnt` decrements.
- Sample:
  - Set `covered[vec_in]`.
  - If `dut_out != EXPECTED[vec_in]`: increment `mismatch_cnt` (saturating), assert `err_pulse`, and capture `first_fail_vec` if `first_fail_valid` is 0.
  - If `covered` (including this bit) is all-ones → DONE. Otherwise → WAIT with the idle counter ← 0.
- WAIT:
  - A change → SETTLE with `cnt` ← SETTLE.
  - Otherwise the idle counter increments. When it reaches TIMEOUT → DONE with `timeout`=1.
- Re-applying an already covered vector re-checks it; further mismatches are counted again.
- DONE: `done`=1, `busy`=0, `pass` = (`mismatch_cnt`==0 && !`timeout`). Results hold. `start` restarts exactly as from IDLE.
- `start` in SETTLE or WAIT aborts the session and restarts it with cleared results.
- `busy`=1 in SETTLE and WAIT only.

## Timing
- Reset values: state IDLE; all outputs 0; `prev_vec` and counters 0.
- `rst` mid-session returns the block to IDLE immediately and asynchronously, with all results cleared.
- Sample latency: the sample occurs on the (SETTLE+1)th edge after the change edge, provided no further change occurs. With SETTLE=0 it is the next edge. Sample results are visible after that edge.
- `err_pulse` is high for exactly the one cycle following the sampling edge.
- `done`/`pass` assert in the cycle after the final sampling edge, or after the TIMEOUT-th idle edge.
- The session's first vector counts from the start edge. `vec_in` need not change after `start`.
- A vector held for fewer than SETTLE+1 edges is never sampled.

## Test plan
- F1 default, 00/01/10/11 each held 10 cycles, correct DUT → `covered`=4'b1111, `mismatch_cnt`=0, `pass`=1, `done` 1 cycle after the 4th sample (SETTLE=3).
- Same sequence, `dut_out` forced 1 → mismatches on 00 and 01: `err_pulse` twice, `mismatch_cnt`=2, `first_fail_vec`=2'b00, `pass`=0.
- Vector 01 held only 2 cycles (SETTLE=3) → 01 not covered; session waits; after 64 idle edges `timeout`=1, `pass`=0, `covered`=4'b1101.
- `vec_in` toggles every 2 cycles → no sample ever taken; `cnt` keeps reloading; `covered` stays 0.
- CNT_W=2, wrong DUT, vector pair 00/01 repeated 6 times → `mismatch_cnt` saturates at 3 and does not wrap.
- `rst` asserted mid-SETTLE with `covered`=4'b0011 → all outputs 0 immediately. `start` mid-WAIT → results cleared and a new session begins.
